rv32m_mdu: RTL and testbench
============================

Name: rv32m_mdu

Overview:
Iterative RV32M multiply/divide unit placed beside the ALU.
- Consumes the register-file read data (RD1/RD2) for an M-extension instruction.
- Drives the register-file write port (WE3/A3/WD3) through a one-cycle writeback pulse.
- Asserts busy so the core stalls the PC and suppresses its own writeback while an operation is in flight.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 5, iteration counter width (log2 XLEN)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-low
start  input  1  request: sample operands this cycle (honoured only in IDLE)
funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  XLEN  operand A (from RD1)
rs2_val  input  XLEN  operand B (from RD2)
rd_addr  input  5  destination register
busy  output  1  high in CALC and DONE
done  output  1  one-cycle completion pulse (state DONE)
wb_we  output  1  write enable to regfile WE3; equals done AND rd_q!=0
wb_addr  output  5  latched rd, to A3
wb_data  output  XLEN  result, to WD3

Behaviour:
Reset (rst low, any state):
- State goes to IDLE.
- busy, done, wb_we, wb_addr, wb_data all become 0.
- An in-flight result is discarded and never written.

States: IDLE, CALC, DONE.

IDLE:
- On the edge where start=1, latch funct3, rd_addr, and the operand magnitudes plus result-sign flags.
- Clear the counter.
- Go to CALC, or straight to DONE on a fast path (below).
- start=0 keeps the unit in IDLE.

CALC:
- Performs one iteration per edge.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring step on a 33-bit partial remainder.
- After the 32nd iteration (counter==31), move to DONE; the final sign correction is applied on that same edge.

DONE:
- done=1 for exactly one cycle; wb_data is valid.
- Next edge returns to IDLE.

Latency:
- Start sampled at edge k; done high between edges k+32 and k+33.
- Next start is accepted at edge k+33 or later.

Signedness:
- MUL, MULH: both operands signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU, DIVU, REMU: unsigned.
- DIV, REM: signed.
- Magnitudes are computed on entry and the result is negated on exit when its sign flag is set.
- Remainder sign follows the dividend.

Result select:
- MUL returns product[31:0].
- MULH/MULHSU/MULHU return product[63:32].

Fast paths (IDLE to DONE in one edge, done one cycle after start):
- Divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU return rs1_val.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000; REM returns 0.

Boundary conditions:
- start while busy: ignored; latched operands are unaffected.
- rd_addr==0: full operation runs and done pulses, but wb_we stays 0.
- Operand inputs may change after the start edge without affecting the result.
- wb_data and wb_addr hold their last value until the next DONE; only wb_we qualifies the write.

Decomposition:
- Package rv32m_pkg:
  - funct3 localparams (F3_MUL..F3_REMU)
  - state encoding (ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2)
  - XLEN constant
- Sub-module rv32m_mdu_step: combinational single-iteration datapath (add-shift / restoring subtract), instantiated once.
- FSM, counter, sign handling and output registers stay in rv32m_mdu.

Test Plan:
1. MUL 7 x 6, rd=5: start at edge k -> busy at k..k+33, done at k+32 to k+33, wb_we=1, wb_addr=5, wb_data=0x0000002A.
2. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
3. DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
4. DIVU 100 / 0 -> done one cycle after start, wb_data=0xFFFFFFFF. REM 0x80000000 / 0xFFFFFFFF -> done one cycle after start, wb_data=0.
5. MUL with rd=0 -> done pulses, wb_we stays 0. Second start at cycle 10 while busy -> ignored; first result unchanged, exactly one done pulse.
6. Drive rst low at cycle 15 of a DIV -> busy/done/wb_we drop immediately (asynchronously), no write occurs. After release, a new MUL 3 x 3 returns 9 at nominal latency.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared constants for the RV32M multiply/divide unit: operand width, funct3 codes, FSM states.
package rv32m_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rv32m_mdu_step.sv
// One iteration of the MDU datapath: shift-add multiply or restoring divide on a 64-bit accumulator.
module rv32m_mdu_step
    import rv32m_pkg::*;
(
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opb,
    output logic [2*XLEN-1:0]   acc_next
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Divide keeps the partial remainder in acc[63:32] and the dividend/quotient in acc[31:0].
    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff    = shifted - {1'b0, opb};
        if (is_div) begin
            if (diff[XLEN]) begin
                acc_next = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/rv32m_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle FSM with sign handling and regfile writeback pulse.
module rv32m_mdu #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  rs1_val,
    input  logic [XLEN-1:0]  rs2_val,
    input  logic [4:0]       rd_addr,
    output logic             busy,
    output logic             done,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [XLEN-1:0]  wb_data
);
    import rv32m_pkg::*;

    state_e            state;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic              neg_q;
    logic [XLEN-1:0]   opb_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] step_acc;

    logic              a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, fast_hit;
    logic [XLEN-1:0]   fast_data;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    rv32m_mdu_step u_step (
        .is_div   (f3_q[2]),
        .acc      (acc_q),
        .opb      (opb_q),
        .acc_next (step_acc)
    );

    always_comb begin
        a_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH) || (funct3 == F3_MULHSU)
                || (funct3 == F3_DIV) || (funct3 == F3_REM);
        b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH)
                || (funct3 == F3_DIV) || (funct3 == F3_REM);
        a_neg    = a_signed & rs1_val[XLEN-1];
        b_neg    = b_signed & rs2_val[XLEN-1];
        mag_a    = a_neg ? -rs1_val : rs1_val;
        mag_b    = b_neg ? -rs2_val : rs2_val;
        // Remainder takes the dividend's sign; everything else the XOR of operand signs.
        neg_in   = (funct3 == F3_REM) ? a_neg : (a_neg ^ b_neg);

        div_zero = funct3[2] && (rs2_val == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM))
                && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        fast_hit = div_zero | div_ovf;
        if (div_zero) begin
            fast_data = funct3[1] ? rs1_val : '1;
        end else begin
            fast_data = funct3[1] ? '0 : rs1_val;
        end

        prod = neg_q ? -step_acc : step_acc;
        quo  = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
        rem  = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
        if (f3_q[2]) begin
            final_res = f3_q[1] ? rem : quo;
        end else begin
            final_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        f3_q  <= funct3;
                        rd_q  <= rd_addr;
                        neg_q <= neg_in;
                        opb_q <= mag_b;
                        acc_q <= {{XLEN{1'b0}}, mag_a};
                        cnt_q <= '0;
                        busy  <= 1'b1;
                        if (fast_hit) begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            wb_we   <= (rd_addr != 5'd0);
                            wb_addr <= rd_addr;
                            wb_data <= fast_data;
                        end else begin
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        wb_we   <= (rd_q != 5'd0);
                        wb_addr <= rd_q;
                        wb_data <= final_res;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    wb_we <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_mdu.sv
// Self-checking bench for rv32m_mdu against an arithmetic reference of the RV32M rules.
module tb_rv32m_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_val = '0;
    logic [31:0] rs2_val = '0;
    logic [4:0]  rd_addr = '0;
    logic        busy, done, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv32m_mdu #(.XLEN(32), .CNT_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .done    (done),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ia = $signed(a);
        ib = $signed(b);
        case (f3)
            3'b000: begin p = sa * sb; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] b);
        if (f3[2] && b == 0) return 0;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 32;
    endfunction

    // Issue one op; lat counts edges after the start edge until done is seen (-1 on timeout).
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] data, output logic we,
                         output logic [4:0] addr, output int lat, output logic busy_ok);
        @(negedge clk);
        funct3 = f3; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'($urandom); funct3 = 3'($urandom);
        lat = -1; busy_ok = 1'b1; data = '0; we = 1'b0; addr = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!busy) busy_ok = 1'b0;
            if (done) begin
                lat = n; data = wb_data; we = wb_we; addr = wb_addr;
                break;
            end
        end
        @(negedge clk);
        if (busy || done) busy_ok = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (wb_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", wb_we); end
        n_cmp++; if (wb_addr !== 5'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", wb_addr); end
        n_cmp++; if (wb_data !== 32'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", wb_data); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_table(input string name, input logic [2:0] f3[], input logic [31:0] a[],
                              input logic [31:0] b[], input logic [31:0] exp[]);
        logic [31:0] d; logic we, bok; logic [4:0] ad; int lat;
        for (int i = 0; i < f3.size(); i++) begin
            do_op(f3[i], a[i], b[i], 5'd5, d, we, ad, lat, bok);
            n_cmp++; if (d !== exp[i]) begin n_bad++;
                $display("FAIL %s[%0d]_data: got %h want %h", name, i, d, exp[i]); end
            n_cmp++; if (lat != ref_latency(f3[i], a[i], b[i])) begin n_bad++;
                $display("FAIL %s[%0d]_latency: got %0d want %0d", name, i, lat,
                         ref_latency(f3[i], a[i], b[i])); end
            n_cmp++; if (we !== 1'b1 || ad !== 5'd5) begin n_bad++;
                $display("FAIL %s[%0d]_wb: got we=%b addr=%0d want we=1 addr=5", name, i, we, ad); end
            n_cmp++; if (bok !== 1'b1) begin n_bad++;
                $display("FAIL %s[%0d]_busy: got %b want 1", name, i, bok); end
        end
    endtask

    task automatic test_rd_zero();
        logic [31:0] d; logic we, bok; logic [4:0] ad; int lat;
        do_op(3'b000, 32'd12, 32'd11, 5'd0, d, we, ad, lat, bok);
        n_cmp++; if (we !== 1'b0) begin n_bad++; $display("FAIL rd0_we: got %b want 0", we); end
        n_cmp++; if (lat != 32) begin n_bad++; $display("FAIL rd0_latency: got %0d want 32", lat); end
        n_cmp++; if (d !== 32'd132) begin n_bad++; $display("FAIL rd0_data: got %h want %h", d, 32'd132); end
    endtask

    task automatic test_busy_start();
        int pulses = 0;
        logic [31:0] d = '0;
        logic [4:0] ad = '0;
        @(negedge clk);
        funct3 = 3'b000; rs1_val = 32'h1234_5678; rs2_val = 32'h0000_0101; rd_addr = 5'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0; rs1_val = 32'd0; rs2_val = 32'd0;
        for (int n = 1; n < 50; n++) begin
            if (n == 10) begin
                funct3 = 3'b101; rs1_val = 32'd99; rs2_val = 32'd0; rd_addr = 5'd3; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin pulses++; d = wb_data; ad = wb_addr; end
        end
        start = 1'b0;
        n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL busy_start_pulses: got %0d want 1", pulses); end
        n_cmp++; if (d !== ref_result(3'b000, 32'h1234_5678, 32'h0000_0101)) begin n_bad++;
            $display("FAIL busy_start_data: got %h want %h", d,
                     ref_result(3'b000, 32'h1234_5678, 32'h0000_0101)); end
        n_cmp++; if (ad !== 5'd9) begin n_bad++; $display("FAIL busy_start_addr: got %0d want 9", ad); end
    endtask

    task automatic test_reset_midop();
        logic [31:0] d; logic we, bok, seen_we = 1'b0; logic [4:0] ad; int lat;
        @(negedge clk);
        funct3 = 3'b100; rs1_val = 32'd1000; rs2_val = 32'd7; rd_addr = 5'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || wb_we !== 1'b0) begin n_bad++;
            $display("FAIL midreset_outputs: got busy=%b done=%b we=%b want 0 0 0", busy, done, wb_we); end
        repeat (3) begin @(negedge clk); if (wb_we) seen_we = 1'b1; end
        rst = 1'b1;
        repeat (40) begin @(negedge clk); if (wb_we) seen_we = 1'b1; end
        n_cmp++; if (seen_we !== 1'b0) begin n_bad++; $display("FAIL midreset_nowrite: got %b want 0", seen_we); end
        n_cmp++; if (wb_data !== 32'd0) begin n_bad++; $display("FAIL midreset_data: got %h want 0", wb_data); end
        do_op(3'b000, 32'd3, 32'd3, 5'd7, d, we, ad, lat, bok);
        n_cmp++; if (d !== 32'd9 || lat != 32 || we !== 1'b1) begin n_bad++;
            $display("FAIL midreset_after: got data=%h lat=%0d we=%b want 9 32 1", d, lat, we); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, d; logic [2:0] f3; logic [4:0] rd, ad; logic we, bok; int lat;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom);
            rd = 5'($urandom);
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 200) - 100; b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            do_op(f3, a, b, rd, d, we, ad, lat, bok);
            n_cmp++; if (d !== ref_result(f3, a, b) || lat != ref_latency(f3, a, b)
                         || we !== (rd != 0) || ad !== rd) begin
                n_bad++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h rd=%0d: got data=%h lat=%0d we=%b addr=%0d want data=%h lat=%0d we=%b addr=%0d",
                         i, f3, a, b, rd, d, lat, we, ad, ref_result(f3, a, b),
                         ref_latency(f3, a, b), (rd != 0), rd);
            end
        end
    endtask

    initial begin
        logic [2:0]  f3_t[];
        logic [31:0] a_t[], b_t[], e_t[];
        test_reset();
        f3_t = '{3'b000}; a_t = '{32'd7}; b_t = '{32'd6}; e_t = '{32'h2A};
        test_table("mul_basic", f3_t, a_t, b_t, e_t);
        f3_t = '{3'b001, 3'b011, 3'b010};
        a_t = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        b_t = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        e_t = '{32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        test_table("mul_high", f3_t, a_t, b_t, e_t);
        f3_t = '{3'b100, 3'b110, 3'b101, 3'b111};
        a_t = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        b_t = '{32'd2, 32'd2, 32'd7, 32'd7};
        e_t = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        test_table("divide", f3_t, a_t, b_t, e_t);
        f3_t = '{3'b101, 3'b110, 3'b100, 3'b111};
        a_t = '{32'd100, 32'h8000_0000, 32'h8000_0000, 32'd55};
        b_t = '{32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
        e_t = '{32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd55};
        test_table("fast_path", f3_t, a_t, b_t, e_t);
        test_rd_zero();
        test_busy_start();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
